uart_transmitter: RTL

Serial transmit half of the UART link, and the counterpart to the existing receiver. It accepts a byte over a single-cycle write strobe and serialises it onto TxD as one frame: start bit, 8 data bits LSB first, even parity bit, stop bit. Bit timing comes from the shared baud_controller: one bit lasts 16 Tx_sample_ENABLE pulses.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_transmitter_if.sv | 21 ++
 rtl/baud_controller.sv | 35 +++
 rtl/uart_transmitter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame states, baud divisors, frame constants and parity helper
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } frame_state_e;

   localparam int SAMPLES_PER_BIT = 16;
   localparam int FRAME_BITS      = 11;
   localparam int BAUD_DIV_W      = 14;

   // Clocks per sample pulse at 50 MHz for 16x oversampling.
   function automatic logic [BAUD_DIV_W-1:0] baud_divisor(input logic [2:0] sel);
      case (sel)
         3'b000:  return 14'd10417;
         3'b001:  return 14'd2604;
         3'b010:  return 14'd651;
         3'b011:  return 14'd326;
         3'b100:  return 14'd163;
         3'b101:  return 14'd81;
         3'b110:  return 14'd54;
         default: return 14'd27;
      endcase
   endfunction

   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// rtl/uart_transmitter_if.sv - byte write handshake and serial status of the UART transmitter
interface uart_transmitter_if #(
   parameter int DATA_BITS = 8
) ();
   logic                 Tx_EN;
   logic                 Tx_WR;
   logic [DATA_BITS-1:0] Tx_DATA;
   logic                 TxD;
   logic                 Tx_BUSY;
   logic                 Tx_DONE;

   modport master (
      output Tx_EN, Tx_WR, Tx_DATA,
      input  TxD, Tx_BUSY, Tx_DONE
   );

   modport slave (
      input  Tx_EN, Tx_WR, Tx_DATA,
      output TxD, Tx_BUSY, Tx_DONE
   );
endinterface

// File: rtl/baud_controller.sv
// rtl/baud_controller.sv - free-running divider producing one sample-enable pulse per divisor period
module baud_controller
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] baud_select,
   output logic       sample_enable_o
);

   logic [BAUD_DIV_W-1:0] div;
   logic [BAUD_DIV_W-1:0] cnt_q, cnt_d;
   logic                  pulse_q, pulse_d;

   assign div = baud_divisor(baud_select);

   // >= keeps the divider from running away when the rate drops to a smaller divisor.
   always_comb begin
      pulse_d = (cnt_q >= div - 14'd1);
      cnt_d   = pulse_d ? '0 : cnt_q + 14'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   assign sample_enable_o = pulse_q;

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - serialises one byte per write as start, 8 data LSB first, even parity, stop
module uart_transmitter #(
   parameter int SAMPLES_PER_BIT = uart_pkg::SAMPLES_PER_BIT,
   parameter int DATA_BITS       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        baud_select,
   uart_transmitter_if.slave tx
);
   import uart_pkg::*;

   localparam int CNT_W = $clog2(SAMPLES_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);

   frame_state_e         state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 parity_q, parity_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 txd_q, txd_d;
   logic                 done_q, done_d;
   logic                 Tx_sample_ENABLE;
   logic                 bit_end;

   baud_controller u_baud (
      .clk             (clk),
      .reset           (reset),
      .baud_select     (baud_select),
      .sample_enable_o (Tx_sample_ENABLE)
   );

   assign bit_end = Tx_sample_ENABLE && (cnt_q == CNT_W'(SAMPLES_PER_BIT - 1));

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;

      if (!tx.Tx_EN) begin
         state_d = IDLE;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         if (state_q != IDLE && Tx_sample_ENABLE) begin
            cnt_d = cnt_q + 1'b1;
         end
         if (bit_end) begin
            cnt_d = '0;
         end
         case (state_q)
            IDLE: begin
               cnt_d = '0;
               // The Tx_DONE cycle still rejects writes so frames are always separated.
               if (tx.Tx_WR && !done_q) begin
                  shift_d  = tx.Tx_DATA;
                  parity_d = even_parity(tx.Tx_DATA);
                  idx_d    = '0;
                  state_d  = START;
               end
            end
            START: begin
               if (bit_end) begin
                  idx_d   = '0;
                  state_d = DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  shift_d = shift_q >> 1;
                  if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                     idx_d   = '0;
                     state_d = PARITY;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  state_d = STOP;
               end
            end
            STOP: begin
               if (bit_end) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         PARITY:  txd_d = parity_d;
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         parity_q <= 1'b0;
         idx_q    <= '0;
         cnt_q    <= '0;
         txd_q    <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         txd_q    <= txd_d;
         done_q   <= done_d;
      end
   end

   assign tx.TxD     = txd_q;
   assign tx.Tx_BUSY = (state_q != IDLE);
   assign tx.Tx_DONE = done_q;

endmodule
